dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single external data-memory port (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata) between two requesters: the CPU M stage and a DMA/debug master.
- Sequences each access with a fixed-latency memory model and a req/ack handshake, and raises cpu_stall so the pipeline freezes while its access is pending.
- The CPU has fixed priority; an anti-starvation counter guarantees the DMA master eventually wins arbitration.

Parameters:
- LAT, 1, memory read latency in cycles: data valid LAT cycles after the address is first presented (LAT >= 1).
- STARVE_MAX, 4, number of consecutive arbitration losses after which DMA wins the next contest (>= 1).
- CW, 3, width of the latency and starvation counters (2^CW > max(LAT, STARVE_MAX)).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request; held with payload until cpu_ack
- cpu_kill  in  1  interrupt flush of the M stage; suppresses CPU grant in IDLE
- cpu_addr  in  32  CPU byte address
- cpu_byteen  in  4  CPU byte write enables; 0 means read
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  read data to CPU, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dma_req  in  1  DMA access request; held until dma_ack
- dma_addr  in  32  DMA byte address
- dma_byteen  in  4  DMA byte write enables; 0 means read
- dma_wdata  in  32  DMA write data
- dma_rdata  out  32  read data to DMA, valid with dma_ack
- dma_ack  out  1  one-cycle completion pulse to DMA
- m_data_addr  out  32  memory address
- m_data_wdata  out  32  memory write data
- m_data_byteen  out  4  memory byte write enables
- m_data_rdata  in  32  memory read data

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, owner=CPU, lat_cnt=0, starve_cnt=0.
  - All acks are 0; m_data_byteen=0, m_data_addr=0, m_data_wdata=0.
  - Reset in the middle of an access drops it silently: no ack is issued and no further byteen is driven.
- States: IDLE, ACCESS, RESP.
- IDLE arbitration. Let creq = cpu_req & ~cpu_kill.
  - creq & dma_req: DMA wins if starve_cnt==STARVE_MAX, else CPU wins.
  - Only one request active: that requester wins.
  - Neither active: stay in IDLE.
  - On a win: owner is registered, lat_cnt=0, next state is ACCESS.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, each time DMA loses to the CPU in IDLE.
  - Clears when DMA is granted, or on any cycle dma_req==0.
- ACCESS:
  - m_data_addr and m_data_wdata follow the owner's payload.
  - m_data_byteen equals the owner's byteen only when lat_cnt==0, else 0 (a write commits exactly once).
  - lat_cnt increments every cycle; when lat_cnt==LAT-1, next state is RESP.
  - Outside ACCESS, m_data_byteen=0 and addr/wdata hold their last value.
- RESP (exactly one cycle):
  - The owner's ack is 1 and its rdata = m_data_rdata (combinational pass-through); next state is IDLE.
  - The non-owner's ack is 0 and its rdata holds its last registered value.
  - Writes also go through RESP, so read and write latency are equal.
- Latency: a request seen in IDLE at cycle t is acked at cycle t+1+LAT. Minimum spacing between accesses is LAT+2 cycles.
- cpu_kill:
  - Sampled only in IDLE.
  - An already granted CPU access completes normally; flush handling is the pipeline's job.
- Requests arriving during ACCESS or RESP wait and are arbitrated in the next IDLE.
- A requester dropping req before its ack is a protocol violation; the arbiter still completes the access and pulses ack.
- cpu_ack and dma_ack are never 1 in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_RESP;
  - owner encoding OWN_CPU=0, OWN_DMA=1;
  - default LAT and STARVE_MAX.
- One natural sub-module: dm_arb_pick, the combinational winner select from creq, dma_req and the starvation-threshold flag. The FSM, counters and muxes stay in the top module.

Test Plan:
- CPU-only read, LAT=1: cpu_req, addr=0x0000_0010, byteen=0 at t0 -> m_data_addr=0x10 at t0+1, cpu_ack=1 at t0+2 with cpu_rdata=m_data_rdata=0xDEADBEEF, cpu_stall=1 during t0..t0+1 and 0 at t0+2.
- DMA write, LAT=3: byteen=4'b0011, wdata=0x1234_5678 -> m_data_byteen=4'b0011 only at t0+1, 0 at t0+2..t0+3, dma_ack at t0+4.
- Simultaneous requests, STARVE_MAX=4, CPU re-requests continuously:
  - CPU is granted 4 times while starve_cnt goes 1..4; the 5th contest is granted to DMA; starve_cnt then returns to 0.
  - cpu_ack and dma_ack never coincide.
- cpu_kill=1 with cpu_req=1 and dma_req=0 in IDLE -> no grant, m_data_byteen stays 0; with dma_req=1 the DMA is granted immediately.
- Reset low during ACCESS of a CPU store, LAT=3 -> next cycle IDLE, byteen=0, no cpu_ack ever issued; after release, a fresh request completes normally.
- Back-to-back CPU reads, LAT=1 -> acks exactly 3 cycles apart; a request arriving during RESP waits for IDLE.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dm_port_arbiter_pkg;

    localparam int unsigned LAT_DEF        = 1;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CW_DEF         = 3;
    localparam int unsigned AW             = 32;
    localparam int unsigned DW             = 32;
    localparam int unsigned BW             = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] byteen;
    } mem_req_t;

endpackage

// File: rtl/dm_port_arbiter_pick.sv
// Combinational winner select: CPU has priority unless the DMA has starved.
module dm_arb_pick
    import dm_port_arbiter_pkg::*;
(
    input  logic   creq_i,
    input  logic   dreq_i,
    input  logic   starved_i,
    output logic   grant_c_o,
    output owner_e owner_c_o
);

    always_comb begin
        grant_c_o = creq_i | dreq_i;
        owner_c_o = OWN_CPU;
        if (dreq_i && (!creq_i || starved_i)) begin
            owner_c_o = OWN_DMA;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between the CPU M stage and a DMA/debug master
// with a fixed-latency access sequence and anti-starvation for the DMA side.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned LAT        = LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned CW         = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_kill,
    input  logic [AW-1:0] cpu_addr,
    input  logic [BW-1:0] cpu_byteen,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [BW-1:0] dma_byteen,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] m_data_addr,
    output logic [DW-1:0] m_data_wdata,
    output logic [BW-1:0] m_data_byteen,
    input  logic [DW-1:0] m_data_rdata
);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [CW-1:0] lat_cnt_q, lat_cnt_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    mem_req_t      mreq_q, mreq_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic     creq_c, starved_c, grant_c;
    owner_e   win_owner_c;
    mem_req_t cpu_pl_c, dma_pl_c;

    assign creq_c    = cpu_req & ~cpu_kill;
    assign starved_c = (starve_cnt_q == CW'(STARVE_MAX));
    assign cpu_pl_c  = {cpu_addr, cpu_wdata, cpu_byteen};
    assign dma_pl_c  = {dma_addr, dma_wdata, dma_byteen};

    dm_arb_pick u_pick (
        .creq_i    (creq_c),
        .dreq_i    (dma_req),
        .starved_i (starved_c),
        .grant_c_o (grant_c),
        .owner_c_o (win_owner_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_c) state_d = ST_ACCESS;
            ST_ACCESS: if (lat_cnt_q == CW'(LAT - 1)) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Payload is captured at grant; byteen lives for the single first ACCESS cycle.
    always_comb begin
        owner_d       = owner_q;
        lat_cnt_d     = lat_cnt_q;
        starve_cnt_d  = starve_cnt_q;
        mreq_d        = mreq_q;
        mreq_d.byteen = '0;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d   = win_owner_c;
                    lat_cnt_d = '0;
                    mreq_d    = (win_owner_c == OWN_DMA) ? dma_pl_c : cpu_pl_c;
                end
            end
            ST_ACCESS: lat_cnt_d = lat_cnt_q + CW'(1);
            ST_RESP: begin
                if (owner_q == OWN_CPU) cpu_rdata_d = m_data_rdata;
                else                    dma_rdata_d = m_data_rdata;
            end
            default: ;
        endcase
        if (!dma_req) begin
            starve_cnt_d = '0;
        end else if (state_q == ST_IDLE && grant_c) begin
            if (win_owner_c == OWN_DMA)  starve_cnt_d = '0;
            else if (!starved_c)         starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            mreq_q       <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mreq_q       <= mreq_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Response stage: owner sees memory data directly, the other side holds.
    always_comb begin
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        cpu_rdata = cpu_rdata_q;
        dma_rdata = dma_rdata_q;
        if (state_q == ST_RESP) begin
            if (owner_q == OWN_CPU) begin
                cpu_ack   = 1'b1;
                cpu_rdata = m_data_rdata;
            end else begin
                dma_ack   = 1'b1;
                dma_rdata = m_data_rdata;
            end
        end
    end

    assign cpu_stall     = cpu_req & ~cpu_ack;
    assign m_data_addr   = mreq_q.addr;
    assign m_data_wdata  = mreq_q.wdata;
    assign m_data_byteen = mreq_q.byteen;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter; one instance at LAT=1 and one at LAT=3.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_kill, dma_req;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, m_rdata;
    logic [3:0]  cpu_byteen, dma_byteen;

    logic [31:0] cpu_rdata1, dma_rdata1, m_addr1, m_wdata1;
    logic        cpu_ack1, dma_ack1, cpu_stall1;
    logic [3:0]  m_byteen1;
    logic [31:0] cpu_rdata3, dma_rdata3, m_addr3, m_wdata3;
    logic        cpu_ack3, dma_ack3, cpu_stall3;
    logic [3:0]  m_byteen3;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    dm_port_arbiter #(.LAT(1), .STARVE_MAX(4), .CW(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_kill(cpu_kill), .cpu_addr(cpu_addr),
        .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1),
        .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_byteen(dma_byteen),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .m_data_addr(m_addr1), .m_data_wdata(m_wdata1),
        .m_data_byteen(m_byteen1), .m_data_rdata(m_rdata)
    );

    dm_port_arbiter #(.LAT(3), .STARVE_MAX(4), .CW(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_kill(cpu_kill), .cpu_addr(cpu_addr),
        .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata3),
        .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_byteen(dma_byteen),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata3), .dma_ack(dma_ack3),
        .m_data_addr(m_addr3), .m_data_wdata(m_wdata3),
        .m_data_byteen(m_byteen3), .m_data_rdata(m_rdata)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        cpu_req    = 1'b0; cpu_kill = 1'b0; dma_req = 1'b0;
        cpu_addr   = '0;   cpu_wdata = '0;  cpu_byteen = '0;
        dma_addr   = '0;   dma_wdata = '0;  dma_byteen = '0;
        m_rdata    = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        do_reset();
        chk_eq("rst_byteen1", 32'(m_byteen1), 32'h0);
        chk_eq("rst_addr1",   m_addr1,        32'h0);
        chk_eq("rst_wdata1",  m_wdata1,       32'h0);
        chk_eq("rst_acks1",   32'({cpu_ack1, dma_ack1}), 32'h0);
        chk_eq("rst_byteen3", 32'(m_byteen3), 32'h0);
        chk_eq("rst_addr3",   m_addr3,        32'h0);
        chk_eq("rst_wdata3",  m_wdata3,       32'h0);
        chk_eq("rst_acks3",   32'({cpu_ack3, dma_ack3}), 32'h0);
        chk_eq("rst_stall3",  32'(cpu_stall3), 32'h0);

        // CPU read, LAT=1
        cpu_req = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'h0; m_rdata = 32'hDEADBEEF;
        #1;
        chk_eq("rd_stall_t0", 32'(cpu_stall1), 32'h1);
        tick();
        chk_eq("rd_addr_t1",  m_addr1,          32'h10);
        chk_eq("rd_stall_t1", 32'(cpu_stall1),  32'h1);
        chk_eq("rd_ack_t1",   32'(cpu_ack1),    32'h0);
        tick();
        chk_eq("rd_ack_t2",   32'(cpu_ack1),    32'h1);
        chk_eq("rd_data_t2",  cpu_rdata1,       32'hDEADBEEF);
        chk_eq("rd_stall_t2", 32'(cpu_stall1),  32'h0);
        chk_eq("rd_dack_t2",  32'(dma_ack1),    32'h0);
        cpu_req = 1'b0;
        tick();
        m_rdata = 32'h0;
        #1;
        chk_eq("rd_ack_t3",   32'(cpu_ack1),    32'h0);
        chk_eq("rd_hold_t3",  cpu_rdata1,       32'hDEADBEEF);

        // DMA write, LAT=3
        do_reset();
        dma_req = 1'b1; dma_addr = 32'h40; dma_byteen = 4'b0011; dma_wdata = 32'h12345678;
        m_rdata = 32'hA5A50000;
        #1;
        tick();
        chk_eq("wr_byteen_t1", 32'(m_byteen3), 32'h3);
        chk_eq("wr_wdata_t1",  m_wdata3,       32'h12345678);
        chk_eq("wr_addr_t1",   m_addr3,        32'h40);
        tick();
        chk_eq("wr_byteen_t2", 32'(m_byteen3), 32'h0);
        chk_eq("wr_ack_t2",    32'(dma_ack3),  32'h0);
        tick();
        chk_eq("wr_byteen_t3", 32'(m_byteen3), 32'h0);
        chk_eq("wr_ack_t3",    32'(dma_ack3),  32'h0);
        tick();
        chk_eq("wr_ack_t4",    32'(dma_ack3),  32'h1);
        chk_eq("wr_rdata_t4",  dma_rdata3,     32'hA5A50000);
        chk_eq("wr_cack_t4",   32'(cpu_ack3),  32'h0);
        dma_req = 1'b0;
        tick();
        chk_eq("wr_ack_t5",    32'(dma_ack3),  32'h0);

        // Starvation: both requesting continuously, LAT=1
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h500; dma_req = 1'b1; dma_addr = 32'h600;
        #1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_eq($sformatf("stv_cnt_%0d", k), 32'(u_dut1.starve_cnt_q),
                   (k < 4) ? 32'(k + 1) : ((k == 4) ? 32'h0 : 32'h1));
            chk_eq($sformatf("stv_addr_%0d", k), m_addr1, (k == 4) ? 32'h600 : 32'h500);
            tick();
            chk_eq($sformatf("stv_cack_%0d", k), 32'(cpu_ack1), (k != 4) ? 32'h1 : 32'h0);
            chk_eq($sformatf("stv_dack_%0d", k), 32'(dma_ack1), (k == 4) ? 32'h1 : 32'h0);
            chk_eq($sformatf("stv_both_%0d", k), 32'(cpu_ack1 & dma_ack1), 32'h0);
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();

        // cpu_kill suppresses CPU grant; DMA still wins immediately
        do_reset();
        cpu_req = 1'b1; cpu_kill = 1'b1; cpu_byteen = 4'hF; cpu_addr = 32'h300;
        m_rdata = 32'h77778888;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq($sformatf("kill_byteen_%0d", i), 32'(m_byteen1), 32'h0);
            chk_eq($sformatf("kill_addr_%0d", i),   m_addr1,        32'h0);
            chk_eq($sformatf("kill_ack_%0d", i),    32'(cpu_ack1),  32'h0);
        end
        dma_req = 1'b1; dma_addr = 32'h80; dma_byteen = 4'h1;
        #1;
        tick();
        chk_eq("kill_dbyteen", 32'(m_byteen1), 32'h1);
        chk_eq("kill_daddr",   m_addr1,        32'h80);
        tick();
        chk_eq("kill_dack",    32'(dma_ack1),  32'h1);
        chk_eq("kill_drdata",  dma_rdata1,     32'h77778888);
        chk_eq("kill_cack",    32'(cpu_ack1),  32'h0);
        cpu_req = 1'b0; cpu_kill = 1'b0; dma_req = 1'b0;
        tick();

        // Reset during a CPU store, LAT=3
        do_reset();
        cpu_req = 1'b1; cpu_byteen = 4'hF; cpu_wdata = 32'hCAFEF00D; cpu_addr = 32'h20;
        #1;
        tick();
        chk_eq("rsta_byteen_t1", 32'(m_byteen3), 32'hF);
        reset = 1'b0;
        tick();
        chk_eq("rsta_byteen_t2", 32'(m_byteen3), 32'h0);
        chk_eq("rsta_addr_t2",   m_addr3,        32'h0);
        chk_eq("rsta_ack_t2",    32'(cpu_ack3),  32'h0);
        reset = 1'b1; cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_eq($sformatf("rsta_noack_%0d", i), 32'({cpu_ack3, m_byteen3}), 32'h0);
        end
        cpu_req = 1'b1; cpu_byteen = 4'h0; cpu_addr = 32'h24; m_rdata = 32'h0BADF00D;
        #1;
        tick();
        chk_eq("rsta_faddr",   m_addr3,       32'h24);
        tick();
        tick();
        chk_eq("rsta_fack_t3", 32'(cpu_ack3), 32'h0);
        tick();
        chk_eq("rsta_fack_t4", 32'(cpu_ack3), 32'h1);
        chk_eq("rsta_fdata",   cpu_rdata3,    32'h0BADF00D);
        cpu_req = 1'b0;
        tick();

        // Back-to-back CPU reads, LAT=1: acks every 3 cycles
        do_reset();
        exp_addr = 32'h100;
        cpu_req = 1'b1; cpu_addr = exp_addr; cpu_byteen = 4'h0; m_rdata = 32'h11110000;
        #1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk_eq($sformatf("b2b_ack_%0d", i), 32'(cpu_ack1), (i % 3 == 2) ? 32'h1 : 32'h0);
            if (i % 3 == 1) chk_eq($sformatf("b2b_addr_%0d", i), m_addr1, exp_addr);
            if (i % 3 == 2) begin
                exp_addr = exp_addr + 32'h4;
                cpu_addr = exp_addr;
            end
        end
        cpu_req = 1'b0;
        tick();

        // Request dropped early still completes
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h200;
        #1;
        tick();
        cpu_req = 1'b0;
        tick();
        chk_eq("drop_ack",    32'(cpu_ack1), 32'h1);
        tick();
        chk_eq("drop_ack_end", 32'(cpu_ack1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
